// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width and receiver state encoding.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH  = 8;
  localparam int unsigned SPI_STATE_W     = 2;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser for asynchronous SPI pins.
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_receiver.sv
// Mode-0 SPI peripheral receiver with valid/ack output holding register.
// Optional o_frame_err port enabled by defining SPI_RECEIVER_FRAME_ERR_EN.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_s_clk,
  input  logic                  i_ss,
  input  logic                  i_mosi,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ack,
  output logic                  o_busy,
  output logic                  o_overrun
`ifdef SPI_RECEIVER_FRAME_ERR_EN
  ,
  output logic                  o_frame_err
`endif
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic ss_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_d;
  logic sclk_rise;
  logic rise_q;
  logic mosi_q;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_s_clk),
    .o_q   (sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ss),
    .o_q   (ss_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_mosi),
    .o_q   (mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_d;

  // Registered rise strobe with the mosi bit sampled alongside it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_d <= 1'b0;
      rise_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      rise_q <= sclk_rise;
      mosi_q <= mosi_s;
    end
  end

  logic [SPI_STATE_W-1:0] state;
  logic [SPI_STATE_W-1:0] state_n;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [DATA_WIDTH-1:0]  shreg_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic [DATA_WIDTH-1:0]  data_n;
  logic                   valid_n;
  logic                   busy_n;
  logic                   overrun_n;
  logic                   complete;
  logic [DATA_WIDTH-1:0]  shifted;
`ifdef SPI_RECEIVER_FRAME_ERR_EN
  logic                   frame_err_n;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_WAIT_IDLE;
      shreg        <= '0;
      cnt          <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef SPI_RECEIVER_FRAME_ERR_EN
      o_frame_err  <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      cnt          <= cnt_n;
      o_data       <= data_n;
      o_data_valid <= valid_n;
      o_busy       <= busy_n;
      o_overrun    <= overrun_n;
`ifdef SPI_RECEIVER_FRAME_ERR_EN
      o_frame_err  <= frame_err_n;
`endif
    end
  end

  // Next-state, shift/count and output-register logic
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    data_n    = o_data;
    valid_n   = o_data_valid;
    overrun_n = 1'b0;
    complete  = 1'b0;
    shifted   = {shreg[DATA_WIDTH-2:0], mosi_q};
`ifdef SPI_RECEIVER_FRAME_ERR_EN
    frame_err_n = 1'b0;
`endif

    if (o_data_valid && i_data_ack) begin
      valid_n = 1'b0;
    end

    case (state)
      ST_WAIT_IDLE: begin
        if (ss_s) begin
          state_n = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!ss_s) begin
          state_n = ST_SHIFT;
          cnt_n   = '0;
          shreg_n = '0;
        end
      end
      ST_SHIFT: begin
        if (rise_q) begin
          shreg_n = shifted;
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            complete = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        // A byte finishing in the same cycle as deselect is still committed
        if (ss_s) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          shreg_n = '0;
`ifdef SPI_RECEIVER_FRAME_ERR_EN
          if ((cnt != '0) && !complete) begin
            frame_err_n = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_n = ST_WAIT_IDLE;
      end
    endcase

    if (complete) begin
      if (!o_data_valid || i_data_ack) begin
        data_n  = shifted;
        valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end

    busy_n = (state_n == ST_SHIFT);
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: latency, back-to-back, overrun, ack race, aborts.
module tb_spi_receiver;

  localparam int S = 2;

`ifdef SPI_RECEIVER_FRAME_ERR_EN
  localparam int FE_EXP = 1;
`else
  localparam int FE_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       s_clk;
  logic       ss;
  logic       mosi;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       ack;
  logic       o_busy;
  logic       o_overrun;
  logic       frame_err;

  always #5 clk = ~clk;

  spi_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(S)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_s_clk      (s_clk),
    .i_ss         (ss),
    .i_mosi       (mosi),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ack   (ack),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
`ifdef SPI_RECEIVER_FRAME_ERR_EN
    ,
    .o_frame_err  (frame_err)
`endif
  );

`ifndef SPI_RECEIVER_FRAME_ERR_EN
  assign frame_err = 1'b0;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  int         ovr_cnt  = 0;
  int         fe_cnt   = 0;
  int         vcnt     = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] v_last = 8'h00;
  logic [7:0] v_prev = 8'h00;

  // Event monitor: pulse counts and values captured at each valid rise
  always @(posedge clk) begin
    prev_valid <= o_data_valid;
    if (o_overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (o_data_valid && !prev_valid) begin
      vcnt   <= vcnt + 1;
      v_prev <= v_last;
      v_last <= o_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: plain; 1: check valid latency on last bit; 2: ack on completion cycle
  task automatic send_bits(input logic [7:0] b, input int nbits, input int mode);
    for (int i = 7; i >= 8 - nbits; i--) begin
      s_clk = 1'b0;
      mosi  = b[i];
      tick(4);
      s_clk = 1'b1;
      if (i == 0 && mode == 1) begin
        tick(S + 1);
        check("valid_before_latency", 32'(o_data_valid), 32'd0);
        tick(1);
        check("valid_at_latency", 32'(o_data_valid), 32'd1);
        check("data_at_latency", 32'(o_data), 32'hF1);
      end else if (i == 0 && mode == 2) begin
        tick(S + 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end else begin
        tick(4);
      end
    end
  endtask

  task automatic end_frame();
    s_clk = 1'b0;
    tick(4);
    ss = 1'b1;
    tick(6);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  int v0, o0, f0;

  initial begin
    rst = 1'b1; ss = 1'b1; s_clk = 1'b0; mosi = 1'b0; ack = 1'b0;
    tick(4);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_valid", 32'(o_data_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    rst = 1'b0;
    tick(6);

    // Single byte 0xF1 with latency and busy timing
    ss = 1'b0;
    tick(S);
    check("busy_before", 32'(o_busy), 32'd0);
    tick(1);
    check("busy_rise", 32'(o_busy), 32'd1);
    tick(2);
    send_bits(8'hF1, 8, 1);
    end_frame();
    check("busy_after_frame", 32'(o_busy), 32'd0);
    ack_pulse();
    check("ack_clears_valid", 32'(o_data_valid), 32'd0);
    check("data_kept_after_ack", 32'(o_data), 32'hF1);

    // Back-to-back 0xF1, 0x0E under one select, acked
    v0 = vcnt; o0 = ovr_cnt;
    ss = 1'b0;
    tick(4);
    send_bits(8'hF1, 8, 0);
    ack_pulse();
    send_bits(8'h0E, 8, 0);
    ack_pulse();
    end_frame();
    check("b2b_valid_events", 32'(vcnt - v0), 32'd2);
    check("b2b_first", 32'(v_prev), 32'hF1);
    check("b2b_second", 32'(v_last), 32'h0E);
    check("b2b_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    // Overrun: 0xAA unacked then 0x55
    o0 = ovr_cnt;
    ss = 1'b0;
    tick(4);
    send_bits(8'hAA, 8, 0);
    send_bits(8'h55, 8, 0);
    tick(2);
    check("ovr_pulse_once", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_data_kept", 32'(o_data), 32'hAA);
    check("ovr_valid", 32'(o_data_valid), 32'd1);

    // Ack on the exact completion cycle of 0x55
    o0 = ovr_cnt; v0 = vcnt;
    send_bits(8'h55, 8, 2);
    check("race_data", 32'(o_data), 32'h55);
    check("race_valid", 32'(o_data_valid), 32'd1);
    end_frame();
    check("race_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    check("race_valid_no_dip", 32'(vcnt - v0), 32'd0);
    ack_pulse();

    // Deselect after 3 bits, then a clean 0x3C
    v0 = vcnt; f0 = fe_cnt;
    ss = 1'b0;
    tick(4);
    send_bits(8'hA0, 3, 0);
    end_frame();
    check("partial_no_valid", 32'(vcnt - v0), 32'd0);
    check("partial_frame_err", 32'(fe_cnt - f0), 32'(FE_EXP));
    check("partial_valid_low", 32'(o_data_valid), 32'd0);
    ss = 1'b0;
    tick(4);
    send_bits(8'h3C, 8, 0);
    end_frame();
    check("after_partial_data", 32'(o_data), 32'h3C);
    check("after_partial_events", 32'(vcnt - v0), 32'd1);
    ack_pulse();

    // Select held low through reset release: must not join mid-stream
    ss = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    v0 = vcnt;
    send_bits(8'hF0, 4, 0);
    s_clk = 1'b0;
    tick(4);
    check("midstream_not_busy", 32'(o_busy), 32'd0);
    check("midstream_no_valid", 32'(vcnt - v0), 32'd0);
    check("midstream_data_reset", 32'(o_data), 32'h0);
    ss = 1'b1;
    tick(6);
    ss = 1'b0;
    tick(4);
    send_bits(8'h81, 8, 0);
    end_frame();
    check("fresh_frame_data", 32'(o_data), 32'h81);
    check("fresh_frame_valid", 32'(o_data_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
